controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; 0 = reset, 1 = run.
REQ-003 IR  in  8  current instruction from instruction register; opcode = IR[7:4], IR[3:0] ignored.
REQ-004 Z  in  1  accumulator-zero flag (1 when AC output == 8'h00).
REQ-005 PCinc  out  1  program counter increment strobe.
REQ-006 PCload  out  1  program counter load strobe (PC <= memory data).
REQ-007 MARload  out  1  memory address register load strobe.
REQ-008 MARsel  out  1  MAR source: 0 = PC, 1 = memory data bus.
REQ-009 Mread  out  1  memory read enable.
REQ-010 Mwrite  out  1  memory write enable (data = AC output).
REQ-011 IRload  out  1  instruction register load strobe.
REQ-012 ACload  out  1  accumulator load strobe.
REQ-013 ALUop  out  3  ALU operation select.
REQ-014 halt  out  1  high while stopped in HALT.

Function
REQ-015 Opcodes: 0 NOP, 1 LDA a, 2 STA a, 3 ADD a, 4 SUB a, 5 AND a, 6 OR a, 7 NOT, 8 JMP a, 9 JZ a, A INC, F HLT; B-E execute as NOP.
REQ-016 Operand opcodes (1-6, 8, 9) are two bytes; the second byte is address a.
REQ-017 ALUop: 000 PASS B, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 NOT A, 110 INC A; 111 is unused and never driven.
REQ-018 States: F0, F1, DEC, A0, A1, EX, HALT; outputs are Moore, decoded from state and the IR opcode; ALUop = 000 in every state except DEC and EX.
REQ-019 F0: MARload=1, MARsel=0; next F1.
REQ-020 F1: Mread=1, IRload=1, PCinc=1; next DEC.
REQ-021 DEC: NOT/INC assert ACload with ALUop 101/110 and go to F0; NOP/unused opcodes go to F0; HLT goes to HALT; operand opcodes go to A0.
REQ-022 A0: MARload=1, MARsel=0; next A1.
REQ-023 A1 for JMP: Mread=1, PCload=1; next F0.
REQ-024 A1 for JZ: Mread=1; if Z=1, PCload=1, otherwise PCinc=1; Z is sampled in this cycle; next F0.
REQ-025 A1 for all other operand opcodes: Mread=1, MARload=1, MARsel=1, PCinc=1; next EX.
REQ-026 EX for LDA/ADD/SUB/AND/OR: Mread=1, ACload=1, ALUop 000/001/010/011/100; EX for STA: Mwrite=1.
REQ-027 EX always goes next to F0.
REQ-028 HALT: halt=1 and all strobes 0; the block stays in HALT until reset.
REQ-029 Cycle counts: one-byte instructions 3 cycles; JMP/JZ 5; LDA/STA/ALU ops 6.
REQ-030 Mread and Mwrite are never both high; PCinc and PCload are never both high.

Reset
REQ-031 While rst=0: state = F0; every strobe = 0, ALUop = 000, halt = 0, including any reset asserted mid-instruction.
REQ-032 After rst deasserts, the first rising edge executes F0.

Structure
REQ-033 A shared package cpu_pkg holds the opcode constants, the ALUop constants and the state encoding.
REQ-034 There are no sub-modules; the block is a single state register plus next-state and output decode.

Verification
REQ-035 Reset release, IR=8'h00: strobe sequence is F0 MARload, F1 Mread+IRload+PCinc, DEC none, then back to F0 MARload on cycle 4.
REQ-036 IR=8'h3x (ADD): cycle 6 has ACload=1, ALUop=001, Mread=1; cycle 7 has MARload=1, MARsel=0.
REQ-037 IR=8'h9x with Z=1 in A1: PCload=1, PCinc=0; repeat with Z=0: PCinc=1, PCload=0.
REQ-038 IR=8'h2x (STA): cycle 6 has Mwrite=1 and Mread=0; ACload stays 0 for the whole instruction.
REQ-039 IR=8'hF0: halt=1 from cycle 4 onward for 20 or more cycles, all strobes 0; pulse rst=0, then F0 resumes.
REQ-040 Assert rst=0 asynchronously during A1 of LDA: all outputs drop to 0 immediately, without waiting for a clock edge; after release, execution restarts at F0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, ALU operation codes
// and the controller state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_NOT  = 3'b101;
  localparam logic [2:0] ALU_INC  = 3'b110;

  typedef enum logic [2:0] {
    S_F0   = 3'd0,
    S_F1   = 3'd1,
    S_DEC  = 3'd2,
    S_A0   = 3'd3,
    S_A1   = 3'd4,
    S_EX   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  // Opcodes that carry a second (address) byte.
  function automatic logic has_operand(input logic [3:0] op);
    return (op >= OP_LDA && op <= OP_OR) || op == OP_JMP || op == OP_JZ;
  endfunction

endpackage

// File: rtl/controller.sv
// Moore control FSM for the accumulator CPU: fetch, decode, operand fetch
// and execute, with strobes decoded from the state and the IR opcode.
module controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] IR,
  input  logic       Z,
  output logic       PCinc,
  output logic       PCload,
  output logic       MARload,
  output logic       MARsel,
  output logic       Mread,
  output logic       Mwrite,
  output logic       IRload,
  output logic       ACload,
  output logic [2:0] ALUop,
  output logic       halt
);

  state_e     state_q, state_d;
  logic [3:0] op;

  assign op = IR[7:4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_F0;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    PCinc   = 1'b0;
    PCload  = 1'b0;
    MARload = 1'b0;
    MARsel  = 1'b0;
    Mread   = 1'b0;
    Mwrite  = 1'b0;
    IRload  = 1'b0;
    ACload  = 1'b0;
    ALUop   = ALU_PASS;
    halt    = 1'b0;

    case (state_q)
      S_F0: begin
        MARload = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        Mread   = 1'b1;
        IRload  = 1'b1;
        PCinc   = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        state_d = S_F0;
        if (op == OP_NOT) begin
          ACload = 1'b1;
          ALUop  = ALU_NOT;
        end else if (op == OP_INC) begin
          ACload = 1'b1;
          ALUop  = ALU_INC;
        end else if (op == OP_HLT) begin
          state_d = S_HALT;
        end else if (has_operand(op)) begin
          state_d = S_A0;
        end
      end
      S_A0: begin
        MARload = 1'b1;
        state_d = S_A1;
      end
      S_A1: begin
        Mread   = 1'b1;
        state_d = S_F0;
        if (op == OP_JMP) begin
          PCload = 1'b1;
        end else if (op == OP_JZ) begin
          PCload = Z;
          PCinc  = ~Z;
        end else begin
          // Operand byte becomes the data address for the execute cycle.
          MARload = 1'b1;
          MARsel  = 1'b1;
          PCinc   = 1'b1;
          state_d = S_EX;
        end
      end
      S_EX: begin
        state_d = S_F0;
        if (op == OP_STA) begin
          Mwrite = 1'b1;
        end else begin
          Mread  = 1'b1;
          ACload = 1'b1;
          case (op)
            OP_ADD:  ALUop = ALU_ADD;
            OP_SUB:  ALUop = ALU_SUB;
            OP_AND:  ALUop = ALU_AND;
            OP_OR:   ALUop = ALU_OR;
            default: ALUop = ALU_PASS;
          endcase
        end
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: state_d = S_F0;
    endcase

    // Reset silences every output at once, not just at the next edge.
    if (!rst) begin
      state_d = S_F0;
      PCinc   = 1'b0;
      PCload  = 1'b0;
      MARload = 1'b0;
      MARsel  = 1'b0;
      Mread   = 1'b0;
      Mwrite  = 1'b0;
      IRload  = 1'b0;
      ACload  = 1'b0;
      ALUop   = ALU_PASS;
      halt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_controller.sv
// Randomized self-checking bench for the CPU controller: a cycle-position model
// of each instruction predicts every output, plus directed literal checks.
module tb_controller;

  logic       clk;
  logic       rst;
  logic [7:0] ir;
  logic       z;
  logic       PCinc, PCload, MARload, MARsel, Mread, Mwrite, IRload, ACload, halt;
  logic [2:0] ALUop;

  int checks = 0;
  int errors = 0;

  // Model: position k within the current instruction (0 = first fetch cycle).
  int   k = 0;
  logic chk_en = 1'b0;
  int   hcnt = 0;

  // Output bundle: [11]PCinc [10]PCload [9]MARload [8]MARsel [7]Mread
  // [6]Mwrite [5]IRload [4]ACload [3:1]ALUop [0]halt
  logic [11:0] outs;
  assign outs = {PCinc, PCload, MARload, MARsel, Mread, Mwrite, IRload, ACload, ALUop, halt};

  controller dut (
    .clk(clk), .rst(rst), .IR(ir), .Z(z),
    .PCinc(PCinc), .PCload(PCload), .MARload(MARload), .MARsel(MARsel),
    .Mread(Mread), .Mwrite(Mwrite), .IRload(IRload), .ACload(ACload),
    .ALUop(ALUop), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction length in cycles; 0 means it never completes (HLT).
  function automatic int ilen(input logic [3:0] op);
    if (op == 4'hF) return 0;
    if (op >= 4'h1 && op <= 4'h6) return 6;
    if (op == 4'h8 || op == 4'h9) return 5;
    return 3;
  endfunction

  function automatic logic [11:0] expect_out(input int kk, input logic [3:0] op,
                                             input logic zz, input logic r);
    logic [11:0] e;
    e = 12'h000;
    if (!r) return e;
    if (op == 4'hF && kk >= 3) begin
      e[0] = 1'b1;
      return e;
    end
    case (kk)
      0: e[9] = 1'b1;
      1: begin e[11] = 1'b1; e[7] = 1'b1; e[5] = 1'b1; end
      2: begin
        if (op == 4'h7) begin e[4] = 1'b1; e[3:1] = 3'b101; end
        if (op == 4'hA) begin e[4] = 1'b1; e[3:1] = 3'b110; end
      end
      3: e[9] = 1'b1;
      4: begin
        e[7] = 1'b1;
        if (op == 4'h8)      e[10] = 1'b1;
        else if (op == 4'h9) begin
          if (zz) e[10] = 1'b1;
          else    e[11] = 1'b1;
        end else begin
          e[9] = 1'b1; e[8] = 1'b1; e[11] = 1'b1;
        end
      end
      5: begin
        if (op == 4'h2) e[6] = 1'b1;
        else begin
          e[7] = 1'b1;
          e[4] = 1'b1;
          case (op)
            4'h3: e[3:1] = 3'b001;
            4'h4: e[3:1] = 3'b010;
            4'h5: e[3:1] = 3'b011;
            4'h6: e[3:1] = 3'b100;
            default: e[3:1] = 3'b000;
          endcase
        end
      end
      default: e = 12'h000;
    endcase
    return e;
  endfunction

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [11:0] e;
      e = expect_out(k, ir[7:4], z, rst);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL model k=%0d IR=%h Z=%b rst=%b got=%h exp=%h", k, ir, z, rst, outs, e);
      end
      checks++;
      if ((Mread && Mwrite) || (PCinc && PCload)) begin
        errors++;
        $display("FAIL exclusive_strobes got=%h exp=no Mread&Mwrite, no PCinc&PCload", outs);
      end
    end
  end

  task automatic chk_lit(input string name, input logic [11:0] want);
    checks++;
    if (outs !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, outs, want);
    end
  endtask

  // One clock: advance the model at the edge, then drive new inputs.
  task automatic step(input logic [7:0] nir, input logic nz);
    int l;
    @(posedge clk);
    if (!rst) k = 0;
    else if (ir[7:4] == 4'hF) begin
      if (k < 3) k = k + 1;
    end else begin
      l = ilen(ir[7:4]);
      k = (k + 1 == l) ? 0 : k + 1;
    end
    #1;
    z = nz;
    if (k == 0) ir = nir;
  endtask

  initial begin
    rst = 1'b0; ir = 8'h00; z = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk_lit("reset_outs", 12'h000);
    rst = 1'b1;
    #1 chk_lit("release_c1_F0", 12'h200);

    step(8'h00, 1'b0); @(negedge clk); chk_lit("nop_c2_F1", 12'h8A0);
    step(8'h00, 1'b0); @(negedge clk); chk_lit("nop_c3_DEC", 12'h000);
    step(8'h35, 1'b0); @(negedge clk); chk_lit("nop_c4_F0", 12'h200);

    repeat (5) step(8'h35, 1'b0);
    @(negedge clk); chk_lit("add_c6_EX", 12'h092);
    step(8'h9A, 1'b1); @(negedge clk); chk_lit("add_c7_F0", 12'h200);

    repeat (4) step(8'h9A, 1'b1);
    @(negedge clk); chk_lit("jz_z1_A1", 12'h480);
    step(8'h9A, 1'b0);
    repeat (4) step(8'h9A, 1'b0);
    @(negedge clk); chk_lit("jz_z0_A1", 12'h880);
    step(8'h2C, 1'b0);

    for (int i = 0; i < 5; i++) begin
      step(8'h2C, 1'b0);
      @(negedge clk);
      checks++;
      if (ACload !== 1'b0) begin
        errors++;
        $display("FAIL sta_acload got=%b exp=0", ACload);
      end
    end
    chk_lit("sta_c6_EX", 12'h040);
    step(8'h15, 1'b0);

    repeat (4) step(8'h15, 1'b0);
    @(negedge clk); chk_lit("lda_A1", 12'hB80);
    #2 rst = 1'b0; k = 0;
    #1 chk_lit("async_rst_outs", 12'h000);
    step(8'hF0, 1'b0);
    rst = 1'b1;
    @(negedge clk); chk_lit("restart_F0", 12'h200);

    repeat (3) step(8'hF0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk); chk_lit("halt_hold", 12'h001);
      step(8'hF0, 1'b0);
    end
    @(negedge clk);
    #2 rst = 1'b0; k = 0;
    #1 chk_lit("halt_rst_outs", 12'h000);
    step(8'h00, 1'b0);
    rst = 1'b1;
    @(negedge clk); chk_lit("halt_exit_F0", 12'h200);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      step(r, 1'($urandom));
      if (ir[7:4] == 4'hF && k == 3) hcnt++;
      else hcnt = 0;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 99) == 0 || hcnt > 4) begin
        rst = 1'b0;
        k = 0;
        hcnt = 0;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
